md_unit_ctrl: RTL and testbench
===============================

Name: md_unit_ctrl

Overview:
- Sequencing controller for the HI/LO multiply/divide resource in the 5-stage MIPS pipeline.
- Decodes mult/multu/div/divu/mthi/mtlo/mfhi/mflo in the E stage.
- Launches multi-cycle operations, holds the HI/LO registers, tracks busy with a down-counter, and raises a D-stage stall request so no HI/LO instruction reaches E while a result is pending.
- Sits beside the E-stage ALU; its stall output is ORed into the existing hazard stall.

Parameters:
- MUL_LAT, 5, busy cycles for mult/multu (must be >=1)
- DIV_LAT, 10, busy cycles for div/divu (must be >=1)
- CNT_W, 4, counter width (2^CNT_W > max(MUL_LAT, DIV_LAT))

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- instr_D  in  32  D-stage instruction
- instr_E  in  32  E-stage instruction
- valid_E  in  1  E-stage instruction is real (0 = bubble/flushed)
- rs_E  in  32  forwarded rs value in E
- rt_E  in  32  forwarded rt value in E
- busy  out  1  operation in flight
- start  out  1  comb: mult/div launching this cycle
- stall_D  out  1  comb: hold D stage
- md_out  out  32  comb: HI for mfhi, LO for mflo in E, else 0
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Decode (op==0): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011. md_X = any of the eight in stage X.
- Reset (async, reset_n=0):
  - hi=0, lo=0, cnt=0, busy=0.
  - Pending result registers cleared.
  - An in-flight operation is discarded; no commit after release.
- start = valid_E & (mult|multu|div|divu)_E & ~busy.
- At the start edge:
  - Compute the full result from rs_E/rt_E and latch it into pend_hi/pend_lo.
  - Load cnt with MUL_LAT or DIV_LAT.
- busy = (cnt != 0).
- Each edge with cnt != 0: cnt decrements. On the edge where cnt goes 1->0, hi<=pend_hi and lo<=pend_lo.
- Timing: busy is high for exactly LAT cycles after the start edge. The new HI/LO are visible in the first cycle busy=0.
- Arithmetic:
  - mult: signed 64-bit product, {hi,lo}.
  - multu: unsigned 64-bit product, {hi,lo}.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (div or divu): lo=0xFFFFFFFF, hi=rs_E; normal DIV_LAT timing.
- mthi/mtlo: when valid_E & ~busy, hi (or lo) <= rs_E at the edge. If busy, ignored; stall_D guarantees this never occurs (bench asserts it).
- md_out: combinational. The value is valid because stall_D keeps mfhi/mflo out of E while busy.
- stall_D = md_D & (busy | start). Non-HI/LO instructions are never stalled by this block.
- valid_E=0: no start and no mt write, whatever instr_E holds.
- Simultaneous commit edge (cnt 1->0) and new start: cannot occur, because start requires ~busy. The next start is earliest in the cycle busy first reads 0.

Test Plan:
- Reset: reset_n low mid-mult (cnt=3) -> busy=0, hi=lo=0 immediately; after release, hi/lo stay 0 (no late commit).
- mult rs=0xFFFFFFFE (-2), rt=3:
  - Expected: start=1 for one cycle; busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - multu, same operands: hi=0x00000002, lo=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (-7), rt=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> lo=0xFFFFFFFF, hi=7.
- Hazard: mult in E, mflo in D:
  - stall_D=1 in the start cycle and all 5 busy cycles, then 0.
  - mflo then reaches E with md_out = new lo.
  - addu in D during busy -> stall_D=0.
- mthi rs=0x12345678, valid_E=1, idle -> hi=0x12345678 next cycle. Same with valid_E=0 -> hi unchanged, and mult with valid_E=0 -> no start.
- Back-to-back: div then mult in consecutive instructions -> mult is held in D until busy drops, then starts. The final {hi,lo} is the mult result, 10+5 busy cycles total.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide sequencing controller for the 5-stage MIPS pipeline.
// It decodes HI/LO instructions in E and D. A mult/div result is computed
// when the operation starts and held in pending registers. A down-counter
// keeps busy high for the operation's latency. The result is committed to
// HI/LO on the edge where the counter reaches zero.
module md_unit_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr_D,
    input  logic [31:0] instr_E,
    input  logic        valid_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    output logic        busy,
    output logic        start,
    output logic        stall_D,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Decode vector index: 0 mfhi, 1 mthi, 2 mflo, 3 mtlo, 4 mult, 5 multu, 6 div, 7 divu
    logic [7:0] dec_d;
    logic [7:0] dec_e;

    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
        localparam logic [5:0] FN = 6'((gi < 4) ? (16 + gi) : (20 + gi));
        assign dec_d[gi] = (instr_D[31:26] == 6'd0) && (instr_D[5:0] == FN);
        assign dec_e[gi] = (instr_E[31:26] == 6'd0) && (instr_E[5:0] == FN);
    end

    // Register fields between the opcode and funct are irrelevant to this block
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_D[25:6], instr_E[25:6]};

    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [31:0]      pend_hi_reg;
    logic [31:0]      pend_lo_reg;

    logic md_d;
    logic muldiv_e;
    logic is_mul_e;

    assign md_d     = |dec_d;
    assign muldiv_e = |dec_e[7:4];
    assign is_mul_e = dec_e[4] | dec_e[5];

    assign busy    = (cnt_reg != '0);
    assign start   = valid_E & muldiv_e & ~busy;
    assign stall_D = md_d & (busy | start);
    assign hi      = hi_reg;
    assign lo      = lo_reg;

    // mfhi/mflo read the architectural registers directly; stall_D keeps them out of E while busy
    always_comb begin
        md_out = 32'd0;
        if (dec_e[0]) begin
            md_out = hi_reg;
        end else if (dec_e[2]) begin
            md_out = lo_reg;
        end
    end

    // Full-width products
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    assign prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
    assign prod_u = {32'd0, rs_E} * {32'd0, rt_E};

    // Signed division is done on magnitudes, then the signs are restored.
    // This also yields 0x80000000 / -1 = 0x80000000 rem 0 with no special case.
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic        rt_zero;

    assign abs_rs  = rs_E[31] ? (~rs_E + 32'd1) : rs_E;
    assign abs_rt  = rt_E[31] ? (~rt_E + 32'd1) : rt_E;
    assign rt_zero = (rt_E == 32'd0);
    assign quo_mag = rt_zero ? 32'd0 : (abs_rs / abs_rt);
    assign rem_mag = rt_zero ? 32'd0 : (abs_rs % abs_rt);
    assign quo_u   = rt_zero ? 32'd0 : (rs_E / rt_E);
    assign rem_u   = rt_zero ? 32'd0 : (rs_E % rt_E);

    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Select the result of the launching operation; divide by zero gives lo=all ones, hi=dividend
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (dec_e[4]) begin
            {res_hi, res_lo} = prod_s;
        end else if (dec_e[5]) begin
            {res_hi, res_lo} = prod_u;
        end else if (dec_e[6] || dec_e[7]) begin
            if (rt_zero) begin
                res_hi = rs_E;
                res_lo = 32'hFFFF_FFFF;
            end else if (dec_e[6]) begin
                res_lo = (rs_E[31] ^ rt_E[31]) ? (~quo_mag + 32'd1) : quo_mag;
                res_hi = rs_E[31] ? (~rem_mag + 32'd1) : rem_mag;
            end else begin
                res_lo = quo_u;
                res_hi = rem_u;
            end
        end
    end

    // Launch, count down, commit on the last busy edge; mthi/mtlo write only when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg     <= '0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
        end else begin
            if (start) begin
                pend_hi_reg <= res_hi;
                pend_lo_reg <= res_lo;
                cnt_reg     <= is_mul_e ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
            end else if (busy) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    hi_reg <= pend_hi_reg;
                    lo_reg <= pend_lo_reg;
                end
            end
            if (valid_E && !busy) begin
                if (dec_e[1]) begin
                    hi_reg <= rs_E;
                end
                if (dec_e[3]) begin
                    lo_reg <= rs_E;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl. A timestamp-based model checks every
// output on every falling edge. Directed programs run through a small D/E
// pipeline that honours the model's stall. Literal expectations pin the results.
module tb_md_unit_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [31:0] I_NOP    = 32'h0000_0000;
    localparam logic [31:0] I_MFHI   = 32'h0000_0010;
    localparam logic [31:0] I_MTHI   = 32'h0000_0011;
    localparam logic [31:0] I_MFLO   = 32'h0000_0012;
    localparam logic [31:0] I_MTLO   = 32'h0000_0013;
    localparam logic [31:0] I_MULT   = 32'h0000_0018;
    localparam logic [31:0] I_MULTU  = 32'h0000_0019;
    localparam logic [31:0] I_DIV    = 32'h0000_001A;
    localparam logic [31:0] I_DIVU   = 32'h0000_001B;
    localparam logic [31:0] I_ADDU   = 32'h0043_0821;
    localparam logic [31:0] I_LWLIKE = 32'h8C00_0018;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] instr_D = 32'd0;
    logic [31:0] instr_E = 32'd0;
    logic        valid_E = 1'b0;
    logic [31:0] rs_E = 32'd0;
    logic [31:0] rt_E = 32'd0;
    logic        busy;
    logic        start;
    logic        stall_D;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .instr_D(instr_D), .instr_E(instr_E),
        .valid_E(valid_E), .rs_E(rs_E), .rt_E(rt_E), .busy(busy), .start(start),
        .stall_D(stall_D), .md_out(md_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: architectural HI/LO plus one pending result with its completion cycle
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    bit          m_pending = 1'b0;
    int          m_done = 0;
    int          cyc = 0;
    bit          m_stall_q = 1'b0;
    int          n_start = 0;
    int          n_busy = 0;
    int          n_stall = 0;
    logic [31:0] md_seen = 32'd0;

    logic [31:0] p_instr [16];
    logic [31:0] p_rs [16];
    logic [31:0] p_rt [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_op(input logic [31:0] i, input logic [31:0] canon);
        return (i[31:26] == 6'd0) && (i[5:0] == canon[5:0]);
    endfunction

    function automatic bit is_muldiv(input logic [31:0] i);
        return (i[31:26] == 6'd0) && (i[5:0] inside {[6'h18:6'h1B]});
    endfunction

    function automatic bit is_md(input logic [31:0] i);
        return (i[31:26] == 6'd0) && (i[5:0] inside {[6'h10:6'h13], [6'h18:6'h1B]});
    endfunction

    // {hi, lo} from 64-bit integer arithmetic
    function automatic logic [63:0] model_result(input logic [31:0] i, input logic [31:0] a32,
                                                 input logic [31:0] b32);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = longint'($signed(a32));
        sb = longint'($signed(b32));
        ua = {32'd0, a32};
        ub = {32'd0, b32};
        res = 64'd0;
        if (is_op(i, I_MULT)) begin
            res = 64'(sa * sb);
        end else if (is_op(i, I_MULTU)) begin
            res = ua * ub;
        end else if (b32 == 32'd0) begin
            res = {a32, 32'hFFFF_FFFF};
        end else if (is_op(i, I_DIV)) begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            res = {ur[31:0], uq[31:0]};
        end
        return res;
    endfunction

    // Per-cycle comparison against the model, then advance the model across the next rising edge
    always @(negedge clk) begin
        logic        eb, es, estall;
        logic [31:0] emd;
        logic [63:0] r;
        cyc++;
        if (m_pending && cyc > m_done) begin
            m_hi = m_phi;
            m_lo = m_plo;
            m_pending = 1'b0;
        end
        if (!reset_n) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_pending = 1'b0;
        end
        eb = m_pending;
        es = valid_E && is_muldiv(instr_E) && !eb;
        estall = is_md(instr_D) && (eb || es);
        emd = is_op(instr_E, I_MFHI) ? m_hi : (is_op(instr_E, I_MFLO) ? m_lo : 32'd0);
        chk("busy", 32'(busy), 32'(eb));
        chk("start", 32'(start), 32'(es));
        chk("stall_D", 32'(stall_D), 32'(estall));
        chk("md_out", md_out, emd);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (valid_E && (is_op(instr_E, I_MTHI) || is_op(instr_E, I_MTLO)))
            chk("mt_while_busy", 32'(busy), 32'd0);
        if (start) n_start++;
        if (busy) n_busy++;
        if (stall_D) n_stall++;
        if (valid_E && (is_op(instr_E, I_MFLO) || is_op(instr_E, I_MFHI))) md_seen = md_out;
        if (reset_n) begin
            if (es) begin
                r = model_result(instr_E, rs_E, rt_E);
                m_phi = r[63:32];
                m_plo = r[31:0];
                m_pending = 1'b1;
                m_done = cyc + (is_op(instr_E, I_MULT) || is_op(instr_E, I_MULTU) ? MUL_LAT : DIV_LAT);
            end else if (valid_E && !eb) begin
                if (is_op(instr_E, I_MTHI)) m_hi = rs_E;
                if (is_op(instr_E, I_MTLO)) m_lo = rs_E;
            end
        end
        m_stall_q = estall;
    end

    task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic v,
                         input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        instr_D = d;
        instr_E = e;
        valid_E = v;
        rs_E = a;
        rt_E = b;
    endtask

    task automatic set_op(input int k, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        p_instr[k] = i;
        p_rs[k] = a;
        p_rt[k] = b;
    endtask

    task automatic apply(input int d, input int e);
        int di, ei;
        di = (d >= 0) ? d : 0;
        ei = (e >= 0) ? e : 0;
        instr_D = (d >= 0) ? p_instr[di] : I_NOP;
        instr_E = (e >= 0) ? p_instr[ei] : I_NOP;
        valid_E = (e >= 0);
        rs_E = (e >= 0) ? p_rs[ei] : 32'd0;
        rt_E = (e >= 0) ? p_rt[ei] : 32'd0;
    endtask

    // Feed n program entries through D and E, holding D while the model says stall
    task automatic run_prog(input int n, input string name);
        int nxt, d, e, k;
        bit done;
        nxt = 0; d = -1; e = -1; k = 0; done = 1'b0;
        n_start = 0; n_busy = 0; n_stall = 0;
        while (!done && k < 300) begin
            @(posedge clk);
            #1;
            if (!m_stall_q) begin
                e = d;
                if (nxt < n) begin
                    d = nxt;
                    nxt++;
                end else begin
                    d = -1;
                end
            end else begin
                e = -1;
            end
            apply(d, e);
            k++;
            done = (d < 0) && (e < 0) && !m_pending;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d cycles required=completion", name, k);
        end
        $display("prog %s: starts=%0d busy=%0d stalls=%0d hi=%h lo=%h", name, n_start, n_busy, n_stall, hi, lo);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset_n = 1'b1;

        // mthi / mtlo while idle, and a mthi with valid_E=0
        drive(I_NOP, I_MTHI, 1'b1, 32'h1234_5678, 32'd0);
        drive(I_NOP, I_NOP, 1'b0, 32'd0, 32'd0);
        chk("mthi_hi", hi, 32'h1234_5678);
        drive(I_NOP, I_MTLO, 1'b1, 32'hCAFE_F00D, 32'd0);
        drive(I_NOP, I_NOP, 1'b0, 32'd0, 32'd0);
        chk("mtlo_lo", lo, 32'hCAFE_F00D);
        drive(I_NOP, I_MTHI, 1'b0, 32'hDEAD_BEEF, 32'd0);
        drive(I_NOP, I_NOP, 1'b0, 32'd0, 32'd0);
        chk("mthi_invalid_hi", hi, 32'h1234_5678);
        $display("txn mt: hi=%h lo=%h", hi, lo);

        // Bubble mult and a non-zero opcode sharing the mult funct: neither starts
        n_start = 0;
        drive(I_NOP, I_MULT, 1'b0, 32'd5, 32'd7);
        drive(I_NOP, I_LWLIKE, 1'b1, 32'd5, 32'd7);
        drive(I_NOP, I_NOP, 1'b0, 32'd0, 32'd0);
        chk("nostart_count", 32'(n_start), 32'd0);
        chk("nostart_busy", 32'(busy), 32'd0);

        set_op(0, I_MULT, 32'hFFFF_FFFE, 32'd3);
        run_prog(1, "mult");
        chk("mult_starts", 32'(n_start), 32'd1);
        chk("mult_busy_cycles", 32'(n_busy), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        set_op(0, I_MULTU, 32'hFFFF_FFFE, 32'd3);
        run_prog(1, "multu");
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        set_op(0, I_DIV, 32'hFFFF_FFF9, 32'd2);
        run_prog(1, "div");
        chk("div_busy_cycles", 32'(n_busy), 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        set_op(0, I_DIVU, 32'd7, 32'd0);
        run_prog(1, "divu_by_zero");
        chk("divu0_busy_cycles", 32'(n_busy), 32'd10);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'd7);

        set_op(0, I_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_prog(1, "div_overflow");
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);

        // mflo right behind mult is held in D for the start cycle plus all busy cycles
        set_op(0, I_MULT, 32'hFFFF_FFFE, 32'd3);
        set_op(1, I_MFLO, 32'd0, 32'd0);
        run_prog(2, "hazard_mflo");
        chk("hazard_stalls", 32'(n_stall), 32'd6);
        chk("hazard_mflo_value", md_seen, 32'hFFFF_FFFA);

        // Unrelated instructions in D are never held
        set_op(0, I_MULT, 32'd3, 32'd4);
        set_op(1, I_ADDU, 32'd1, 32'd2);
        set_op(2, I_ADDU, 32'd1, 32'd2);
        set_op(3, I_ADDU, 32'd1, 32'd2);
        run_prog(4, "addu_no_stall");
        chk("addu_stalls", 32'(n_stall), 32'd0);
        chk("addu_mult_lo", lo, 32'd12);

        // div then mult back to back: mult waits in D, then runs
        set_op(0, I_DIV, 32'hFFFF_FFF9, 32'd2);
        set_op(1, I_MULT, 32'h0001_0000, 32'h0001_0000);
        run_prog(2, "div_then_mult");
        chk("b2b_starts", 32'(n_start), 32'd2);
        chk("b2b_busy_cycles", 32'(n_busy), 32'd15);
        chk("b2b_hi", hi, 32'd1);
        chk("b2b_lo", lo, 32'd0);

        // Reset while a mult is in flight with cnt=3: nothing commits afterwards
        drive(I_NOP, I_MTHI, 1'b1, 32'h1234_5678, 32'd0);
        drive(I_NOP, I_MULT, 1'b1, 32'hFFFF_FFFE, 32'd3);
        drive(I_NOP, I_NOP, 1'b0, 32'd0, 32'd0);
        drive(I_NOP, I_NOP, 1'b0, 32'd0, 32'd0);
        drive(I_NOP, I_NOP, 1'b0, 32'd0, 32'd0);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) drive(I_NOP, I_NOP, 1'b0, 32'd0, 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_hi", hi, 32'd0);
        chk("postrst_lo", lo, 32'd0);
        $display("txn reset_mid_mult: busy=%0d hi=%h lo=%h", busy, hi, lo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
